// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential non-restoring divider.
package div_pkg;

  localparam int DIV_WIDTH   = 32;
  localparam int DIV_COUNT_W = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FIXUP  = 2'd2,
    DONE   = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One non-restoring division iteration: shift {P,Q} left, then add or
// subtract the divisor depending on the sign of the shifted remainder and
// record the resulting quotient bit. P and D are WIDTH+1 bits, two's complement.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   p,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH:0]   d,
  output logic [WIDTH:0]   p_next,
  output logic [WIDTH-1:0] q_next
);

  logic [WIDTH:0] p_shift;

  // Shift in the next dividend bit, then move the remainder toward zero.
  always_comb begin
    p_shift = {p[WIDTH-1:0], q[WIDTH-1]};
    if (!p_shift[WIDTH]) begin
      p_next = p_shift - d;
    end else begin
      p_next = p_shift + d;
    end
    q_next = {q[WIDTH-2:0], ~p_next[WIDTH]};
  end

endmodule

// File: rtl/nonrestoring_divider.sv
// Sequential signed divider, one non-restoring step per clock.
// Result Z = {remainder, quotient}, truncating toward zero, so the remainder
// carries the dividend's sign.
//
// Handshake: start is a request honoured only in IDLE (busy low). The
// accepting edge raises busy; exactly WIDTH+1 cycles later done pulses for
// one cycle with Z/div_by_zero valid, and busy falls at the end of that
// cycle. Requests while busy are dropped, not queued. Z and div_by_zero hold
// until the next result is written.
module nonrestoring_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] Z,
  output logic               busy,
  output logic               done,
  output logic               div_by_zero,
  output logic [1:0]         dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  div_state_t     state;
  logic [CW-1:0]  count;
  logic [WIDTH:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH:0] d;
  logic [WIDTH-1:0] a_reg;
  logic           sign_a;
  logic           sign_b;
  logic           zero_b;

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   b_ext;
  logic [WIDTH:0]   abs_a;
  logic [WIDTH:0]   abs_b;
  logic [WIDTH:0]   p_next;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   p_fix;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  assign dbg_state = state;

  // Operand magnitudes in WIDTH+1 bits so the most negative value is exact.
  always_comb begin
    a_ext = {a[WIDTH-1], a};
    b_ext = {b[WIDTH-1], b};
    abs_a = a[WIDTH-1] ? -a_ext : a_ext;
    abs_b = b[WIDTH-1] ? -b_ext : b_ext;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .p      (p),
    .q      (q),
    .d      (d),
    .p_next (p_next),
    .q_next (q_next)
  );

  // Final correction and sign restoration. The most-negative / -1 case needs
  // no special path: the magnitude quotient 2^(WIDTH-1) is already the
  // required two's complement pattern and the signs agree, so it is kept.
  always_comb begin
    p_fix = p[WIDTH] ? p + d : p;
    quo   = (sign_a ^ sign_b) ? -q : q;
    rem   = sign_a ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0];
  end

  // Control FSM, iteration counter, datapath registers and output registers.
  always_ff @(posedge clock) begin
    if (clear) begin
      state       <= IDLE;
      count       <= '0;
      p           <= '0;
      q           <= '0;
      d           <= '0;
      a_reg       <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      zero_b      <= 1'b0;
      Z           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= a;
            sign_a <= a[WIDTH-1];
            sign_b <= b[WIDTH-1];
            zero_b <= (b == '0);
            q      <= abs_a[WIDTH-1:0];
            d      <= abs_b;
            p      <= '0;
            count  <= '0;
            busy   <= 1'b1;
            state  <= DIVIDE;
          end
        end
        DIVIDE: begin
          p <= p_next;
          q <= q_next;
          if (count == LAST) begin
            count <= '0;
            state <= FIXUP;
          end else begin
            count <= count + 1'b1;
          end
        end
        FIXUP: begin
          if (zero_b) begin
            Z           <= {a_reg, {WIDTH{1'b1}}};
            div_by_zero <= 1'b1;
          end else begin
            Z           <= {rem, quo};
            div_by_zero <= 1'b0;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nonrestoring_divider.sv
// Bench for nonrestoring_divider: directed cases, start/clear interference
// and randomized signed operands against a truncating arithmetic model.
module tb_nonrestoring_divider;

  localparam int W       = 32;
  localparam int LATENCY = W + 1;

  logic             clock;
  logic             clear;
  logic             start;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic [2*W-1:0]   Z;
  logic             busy;
  logic             done;
  logic             div_by_zero;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;

  // Each entry is {div_by_zero, remainder, quotient}.
  logic [2*W:0] exp_q[$];
  int           acc_q[$];

  nonrestoring_divider #(.WIDTH(W)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .a           (a),
    .b           (b),
    .Z           (Z),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .dbg_state   (dbg_state)
  );

  // Clock and edge counter.
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic check(input string name, input logic [2*W:0] act, input logic [2*W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: signed truncating division from plain integer arithmetic.
  function automatic logic [2*W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    int sa, sb, qq, rr;
    sa = ma;
    sb = mb;
    if (sb == 0) return {1'b1, ma, {W{1'b1}}};
    if (ma == 32'h80000000 && mb == 32'hFFFFFFFF) return {1'b0, 32'h0, 32'h80000000};
    qq = sa / sb;
    rr = sa % sb;
    return {1'b0, W'(rr), W'(qq)};
  endfunction

  // Monitor: every done pops one expectation and checks value and latency.
  always @(negedge clock) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got Z=%h with empty expectation queue", Z);
      end else begin
        logic [2*W:0] e;
        int acc;
        e   = exp_q.pop_front();
        acc = acc_q.pop_front();
        check("result", {div_by_zero, Z}, e);
        check("latency", (2*W+1)'(cycle - acc), (2*W+1)'(LATENCY));
        check("busy_at_done", (2*W+1)'(busy), (2*W+1)'(1));
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy still %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [2*W:0] e);
    wait_idle();
    @(negedge clock);
    a     = ia;
    b     = ib;
    start = 1'b1;
    exp_q.push_back(e);
    @(negedge clock);
    acc_q.push_back(cycle);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    int mode;
    clear = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(negedge clock);
    check("reset_z", (2*W+1)'(Z), '0);
    check("reset_flags", (2*W+1)'({busy, done, div_by_zero}), '0);
    check("reset_state", (2*W+1)'(dbg_state), '0);
    clear = 1'b0;
    @(negedge clock);

    // Directed values and signs.
    issue(32'd7, 32'd2, {1'b0, 32'h1, 32'h3});
    wait_idle();
    repeat (3) @(negedge clock);
    check("z_hold", {div_by_zero, Z}, {1'b0, 32'h1, 32'h3});
    issue(-32'd7, 32'd2, {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(32'd7, -32'd2, {1'b0, 32'h1, 32'hFFFFFFFD});
    issue(-32'd7, -32'd2, {1'b0, 32'hFFFFFFFF, 32'h3});
    issue(32'd5, 32'd0, {1'b1, 32'h5, 32'hFFFFFFFF});
    issue(32'h80000000, 32'hFFFFFFFF, {1'b0, 32'h0, 32'h80000000});

    // A second start mid-divide is dropped.
    issue(32'd100, 32'd9, {1'b0, 32'h1, 32'hB});
    repeat (9) @(negedge clock);
    a     = 32'd3;
    b     = 32'd1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check("busy_after_ignored_start", (2*W+1)'(busy), (2*W+1)'(1));
    wait_idle();

    // Clear mid-divide discards the operation.
    issue(32'd1000, 32'd3, {1'b0, 32'h1, 32'd333});
    repeat (14) @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    exp_q.delete();
    acc_q.delete();
    check("clear_busy_done", (2*W+1)'({busy, done}), '0);
    check("clear_z", (2*W+1)'(Z), '0);
    check("clear_state", (2*W+1)'(dbg_state), '0);
    repeat (40) @(negedge clock);
    issue(32'd100, 32'd7, {1'b0, 32'h2, 32'hE});

    // Randomized signed operands.
    for (int i = 0; i < 40; i++) begin
      mode = $urandom_range(0, 4);
      case (mode)
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = $urandom; rb = $urandom_range(0, 1) ? 32'd1 : 32'hFFFFFFFF; end
        2: begin
          ra = $urandom_range(0, 1000);
          rb = $urandom_range(1001, 100000);
          if ($urandom_range(0, 1)) ra = -ra;
          if ($urandom_range(0, 1)) rb = -rb;
        end
        3: begin
          ra = $urandom_range(0, 1) ? 32'h80000000 : $urandom;
          rb = $urandom_range(0, 1) ? 32'd0 : $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h80000000;
        end
        default: begin
          ra = $urandom_range(0, 255);
          rb = $urandom_range(1, 15);
          if ($urandom_range(0, 1)) ra = -ra;
          if ($urandom_range(0, 1)) rb = -rb;
        end
      endcase
      issue(ra, rb, model(ra, rb));
    end

    wait_idle();
    repeat (5) @(negedge clock);
    check("queue_drained", (2*W+1)'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
